alu_cmd_sequencer: RTL and testbench

- Front-end stage that sits directly upstream of the 4-bit ALU in the tile.
- Assembles two-byte commands from the 8-bit input bus and drives the ALU operands and opcode as registered signals.
- Waits a parameterised ALU latency, then captures the ALU's 8-bit result into a small result FIFO.
- The output mux drains that FIFO, so operands stay stable while results are buffered.

---
 rtl/alu_cmd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Front end for the tile's 4-bit ALU. Two command bytes are assembled from
//   the input bus into registered operands (byte 0 = {A,B}) and opcode
//   (byte 1 = {op,reserved}). After ALU_LAT extra cycles the combinational ALU
//   result is captured into a first-word-fall-through result FIFO that the
//   consumer drains through res_valid/res_data/res_rd.
//
// Handshakes:
//   in_valid/in_ready : a byte transfers at a rising edge where both are high.
//                       in_ready depends on state only, never on in_valid.
//   res_valid/res_rd  : res_valid means res_data holds the FIFO head. res_rd
//                       pops it at the edge. res_rd while empty is ignored.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_data   command byte stream
//   in_ready            sequencer can take a byte (GET_AB / GET_OP)
//   alu_a/alu_b/alu_op  registered ALU operands and opcode
//   alu_result          ALU output, function of alu_a/alu_b/alu_op
//   res_valid/res_data  FIFO not empty / FIFO head (holds last head when empty)
//   res_rd              pop request
//   busy                high while executing (EXEC)
//   cmd_count           completed-command counter, wraps at 8 bits
//   dbg_state           current FSM state for observation
module alu_cmd_sequencer #(
  parameter int ALU_LAT    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_rd,
  output logic       busy,
  output logic [7:0] cmd_count,
  output logic [1:0] dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  typedef enum logic [1:0] {
    GET_AB = 2'd0,
    GET_OP = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_lat_cnt;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic [3:0]    r_alu_op;
  logic [7:0]    r_cmd_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_last;

  logic w_in_ready;
  logic w_busy;
  logic w_load_ab;
  logic w_load_op;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = res_rd && !w_empty;
  // A pop at the same edge frees the slot, so a full FIFO can still accept.
  assign w_push  = (r_state == EXEC) && (r_lat_cnt == 3'd0) && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= GET_AB;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_load_ab  = 1'b0;
    w_load_op  = 1'b0;
    case (r_state)
      GET_AB: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_load_ab = 1'b1;
          w_next    = GET_OP;
        end
      end
      GET_OP: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_load_op = 1'b1;
          w_next    = EXEC;
        end
      end
      EXEC: begin
        w_busy = 1'b1;
        if (w_push) w_next = GET_AB;
      end
      default: w_next = GET_AB;
    endcase
  end

  // Operands only change on an accepted byte, so alu_result stays valid
  // through latency countdown and any full-FIFO stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a     <= 4'd0;
      r_alu_b     <= 4'd0;
      r_alu_op    <= 4'd0;
      r_lat_cnt   <= 3'd0;
      r_cmd_count <= 8'd0;
    end else begin
      if (w_load_ab) begin
        r_alu_a <= in_data[7:4];
        r_alu_b <= in_data[3:0];
      end
      if (w_load_op) begin
        r_alu_op  <= in_data[7:4];
        r_lat_cnt <= LAT_INIT;
      end else if (r_state == EXEC && r_lat_cnt != 3'd0) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
      end
      if (w_push) r_cmd_count <= r_cmd_count + 8'd1;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Remember the visible head so res_data holds it once the FIFO empties.
      if (!w_empty) r_last <= r_mem[r_rd_ptr];
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign cmd_count = r_cmd_count;
  assign res_valid = !w_empty;
  assign res_data  = w_empty ? r_last : r_mem[r_rd_ptr];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer. Two instances share clock and reset:
// index 0 has ALU_LAT=0, index 1 has ALU_LAT=3. A bench-side ALU model drives
// alu_result. A negedge monitor keeps a command-level reference model (byte
// phase, captured operands, expected-result queue, completed count) and checks
// every popped result in order.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic       in_ready  [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [3:0] alu_op    [2];
  logic [7:0] alu_result[2];
  logic       res_valid [2];
  logic [7:0] res_data  [2];
  logic       res_rd    [2];
  logic       busy      [2];
  logic [7:0] cmd_count [2];
  logic [1:0] dbg_state [2];

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [7:0] exp_q [2][$];
  logic       phase [2];
  logic [3:0] a_m   [2];
  logic [3:0] b_m   [2];
  logic [7:0] cnt_m [2];
  logic [7:0] last_pop [2];
  logic       rnd_done [2];

  function automatic logic [7:0] model_alu(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    case (op)
      4'd0:    return 8'(a) + 8'(b);
      4'd1:    return 8'(a) - 8'(b);
      4'd2:    return {4'h0, a & b};
      4'd3:    return {4'h0, a ^ b};
      4'd4:    return 8'(a) * 8'(b);
      default: return {op, a | b};
    endcase
  endfunction

  assign alu_result[0] = model_alu(alu_op[0], alu_a[0], alu_b[0]);
  assign alu_result[1] = model_alu(alu_op[1], alu_a[1], alu_b[1]);

  alu_cmd_sequencer #(.ALU_LAT(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
    .alu_result(alu_result[0]), .res_valid(res_valid[0]), .res_data(res_data[0]),
    .res_rd(res_rd[0]), .busy(busy[0]), .cmd_count(cmd_count[0]), .dbg_state(dbg_state[0])
  );

  alu_cmd_sequencer #(.ALU_LAT(3), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
    .alu_result(alu_result[1]), .res_valid(res_valid[1]), .res_data(res_data[1]),
    .res_rd(res_rd[1]), .busy(busy[1]), .cmd_count(cmd_count[1]), .dbg_state(dbg_state[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Monitor: negedge sees exactly the values the next rising edge acts on.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exp_q[d].delete();
        phase[d] = 1'b0;
        cnt_m[d] = 8'd0;
      end else begin
        if (res_rd[d] && res_valid[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("pop_with_no_expected", 32'(exp_q[d].size()), 32'd1);
          end else begin
            logic [7:0] e;
            e = exp_q[d].pop_front();
            chk($sformatf("pop_data[%0d]", d), 32'(res_data[d]), 32'(e));
            last_pop[d] = e;
          end
        end
        if (in_valid[d] && in_ready[d]) begin
          if (!phase[d]) begin
            a_m[d]   = in_data[d][7:4];
            b_m[d]   = in_data[d][3:0];
            phase[d] = 1'b1;
          end else begin
            exp_q[d].push_back(model_alu(in_data[d][7:4], a_m[d], b_m[d]));
            cnt_m[d]++;
            phase[d] = 1'b0;
          end
        end
      end
    end
  end

  // driver tasks (all called at posedge + 1)
  task automatic send_byte(input int d, input logic [7:0] b);
    logic acc;
    logic done;
    done = 1'b0;
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    for (int i = 0; i < 200 && !done; i++) begin
      acc = in_ready[d];
      @(posedge clk); #1;
      if (acc) done = 1'b1;
    end
    if (!done) chk("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_cmd(input int d, input logic [7:0] b0, input logic [7:0] b1);
    send_byte(d, b0);
    send_byte(d, b1);
    in_valid[d] = 1'b0;
  endtask

  task automatic pop_one(input int d);
    res_rd[d] = 1'b1;
    @(posedge clk); #1;
    res_rd[d] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while ((res_valid[d] || busy[d]) && guard < 100) begin
      pop_one(d);
      guard++;
    end
    chk("drain_empty", 32'(res_valid[d]), 32'd0);
  endtask

  task automatic run_random(input int d, input int n);
    rnd_done[d] = 1'b0;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          in_valid[d] = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_byte(d, 8'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            in_valid[d] = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
          send_byte(d, 8'($urandom));
          in_valid[d] = 1'b0;
        end
        rnd_done[d] = 1'b1;
      end
      begin
        while (!rnd_done[d]) begin
          res_rd[d] = ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
        end
        res_rd[d] = 1'b0;
      end
    join
    drain(d);
    chk("rand_cmd_count", 32'(cmd_count[d]), 32'(cnt_m[d]));
    chk("rand_queue_empty", 32'(exp_q[d].size()), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    int npop;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = 8'h00;
      res_rd[d]   = 1'b0;
      last_pop[d] = 8'h00;
      rnd_done[d] = 1'b0;
    end

    // reset state
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_res_valid", 32'(res_valid[0]), 32'd0);
    chk("rst_res_data", 32'(res_data[0]), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_operands", 32'({alu_a[0], alu_b[0], alu_op[0]}), 32'd0);
    chk("rst_state", 32'(dbg_state[0]), 32'd0);

    // basic command, latency 0, valid held across both bytes
    send_cmd(0, 8'h35, 8'h00);
    chk("t1_busy_after_op", 32'(busy[0]), 32'd1);
    chk("t1_not_yet_valid", 32'(res_valid[0]), 32'd0);
    @(posedge clk); #1;
    chk("t1_res_valid", 32'(res_valid[0]), 32'd1);
    chk("t1_res_data", 32'(res_data[0]), 32'h08);
    chk("t1_cmd_count", 32'(cmd_count[0]), 32'd1);
    chk("t1_operands", 32'({alu_a[0], alu_b[0], alu_op[0]}), 32'h350);
    chk("t1_back_in_get_ab", 32'(in_ready[0]), 32'd1);
    pop_one(0);

    // latency 3
    send_cmd(1, 8'hF1, 8'h00);
    n = 0;
    bad = 0;
    while (busy[1] && n < 20) begin
      n++;
      if (in_ready[1]) bad++;
      @(posedge clk); #1;
    end
    chk("t2_busy_cycles", 32'(n), 32'd4);
    chk("t2_in_ready_low", 32'(bad), 32'd0);
    chk("t2_res_data", 32'(res_data[1]), 32'h10);
    pop_one(1);

    // fill FIFO, stall, release with a single pop
    for (int k = 0; k < 4; k++)
      send_cmd(0, 8'($urandom), {4'($urandom_range(0, 15)), 4'h0});
    @(posedge clk); #1;
    chk("t3_full_valid", 32'(res_valid[0]), 32'd1);
    send_cmd(0, 8'h22, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    chk("t3_stall_busy", 32'(busy[0]), 32'd1);
    chk("t3_stall_state", 32'(dbg_state[0]), 32'd2);
    chk("t3_stall_in_ready", 32'(in_ready[0]), 32'd0);
    chk("t3_stall_count", 32'(cmd_count[0]), 32'(cnt_m[0] - 8'd1));
    pop_one(0);
    chk("t3_released", 32'(busy[0]), 32'd0);
    chk("t3_cmd_count", 32'(cmd_count[0]), 32'(cnt_m[0]));
    npop = 0;
    while (res_valid[0] && npop < 10) begin
      pop_one(0);
      npop++;
    end
    chk("t3_depth_after_release", 32'(npop), 32'd4);
    chk("t3_last_is_fifth", 32'(last_pop[0]), 32'h04);

    // underflow pulses
    pop_one(0);
    pop_one(0);
    chk("t4_empty", 32'(res_valid[0]), 32'd0);
    chk("t4_held_data", 32'(res_data[0]), 32'h04);
    send_cmd(0, 8'h5C, 8'h10);
    @(posedge clk); #1;
    chk("t4_after_underflow", 32'(res_data[0]), 32'hF9);
    pop_one(0);

    // reset between byte 0 and byte 1
    send_byte(0, 8'h9A);
    in_valid[0] = 1'b0;
    chk("t5_pre_rst_a", 32'(alu_a[0]), 32'h9);
    rst = 1'b1;
    #1;
    chk("t5_rst_ab", 32'({alu_a[0], alu_b[0]}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_state", 32'(dbg_state[0]), 32'd0);
    send_cmd(0, 8'h12, 8'h40);
    @(posedge clk); #1;
    chk("t5_new_operands", 32'({alu_a[0], alu_b[0], alu_op[0]}), 32'h124);
    chk("t5_result", 32'(res_data[0]), 32'h02);
    pop_one(0);

    // 256 random commands from reset: count wraps to zero
    do_reset(2);
    run_random(0, 256);
    chk("t6_wrap", 32'(cmd_count[0]), 32'd0);
    run_random(1, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
